// File: rtl/wb_bram_pkg.sv
// Shared types and helpers for the Wishbone-to-BRAM bridge: FSM encoding,
// wait-counter sizing and the memory-window decode.
package wb_bram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_DATA   = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    // A zero-delay build still needs a 1-bit counter to keep the ports legal.
    function automatic int cnt_w(input int delay);
        return (delay < 1) ? 1 : $clog2(delay + 1);
    endfunction

    function automatic logic in_window(input logic [31:0] adr,
                                       input logic [31:0] base,
                                       input int unsigned aw);
        return (adr >> (aw + 2)) == (base >> (aw + 2));
    endfunction

endpackage

// File: rtl/wb_bram_bridge_if.sv
// Wishbone-classic slave bus bundle between the user-project bus and the bridge.
interface wb_bram_bridge_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_bram_wait_cnt.sv
// Loadable down-counter pacing the emulated memory latency; done flags the last
// wait cycle (count == 1). Holds at zero, never wraps.
module wb_bram_wait_cnt #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RSTN,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         done
);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == W'(1));

endmodule

// File: rtl/wb_bram_bridge.sv
// Wishbone-classic slave driving a sync-read byte-writable RAM; ack at T+DELAY+3, one per request.
// WB_BRAM_ADDR_CHECK_EN: requests outside BASE_ADDR's window are acked at T+1 with zero data, no RAM access.
module wb_bram_bridge
    import wb_bram_pkg::*;
#(
    parameter int          RAM_AW    = 7,
    parameter int          DELAY     = 10,
    parameter logic [31:0] BASE_ADDR = 32'h3800_0000
) (
    input  logic              CLK,
    input  logic              RSTN,
    wb_bram_bridge_if.slave   wbs,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_a,
    output logic [31:0]       ram_di,
    input  logic [31:0]       ram_do
);

    localparam int CW = cnt_w(DELAY);

    state_t          state, state_nxt;
    logic            req;
    logic            addr_ok;
    logic            addr_unused;
    logic            we_l;
    logic [3:0]      sel_l;
    logic            abort;
    logic [31:0]     rd_dat;
    logic            cnt_load;
    logic            cnt_done;
    logic [CW-1:0]   cnt_val;

    assign req = wbs.wbs_cyc_i & wbs.wbs_stb_i;

`ifdef WB_BRAM_ADDR_CHECK_EN
    assign addr_ok     = in_window(wbs.wbs_adr_i, BASE_ADDR, RAM_AW);
    assign addr_unused = ^wbs.wbs_adr_i[1:0];
`else
    // Window decode kept alive only so the parameter and upper bits are consumed.
    assign addr_ok     = 1'b1;
    assign addr_unused = in_window(wbs.wbs_adr_i, BASE_ADDR, RAM_AW) ^ (^wbs.wbs_adr_i[1:0]);
`endif

    assign cnt_load = (state == ST_IDLE) && req;

    wb_bram_wait_cnt #(.W(CW)) u_wait_cnt (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .load     (cnt_load),
        .load_val (CW'(DELAY)),
        .dec      (state == ST_WAIT),
        .count    (cnt_val),
        .done     (cnt_done)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (!addr_ok)         state_nxt = ST_RESP;
                    else if (DELAY == 0)  state_nxt = ST_ACCESS;
                    else                  state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!wbs.wbs_cyc_i)       state_nxt = ST_IDLE;
                else if (cnt_done)        state_nxt = ST_ACCESS;
            end
            ST_ACCESS: state_nxt = ST_DATA;
            ST_DATA:   state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state  <= ST_IDLE;
            ram_a  <= '0;
            ram_di <= '0;
            we_l   <= 1'b0;
            sel_l  <= 4'h0;
            abort  <= 1'b0;
            rd_dat <= '0;
        end else begin
            state <= state_nxt;
            if (cnt_load) begin
                ram_a  <= wbs.wbs_adr_i[RAM_AW+1:2];
                ram_di <= wbs.wbs_dat_i;
                we_l   <= wbs.wbs_we_i;
                sel_l  <= wbs.wbs_sel_i;
                abort  <= 1'b0;
                if (!addr_ok) rd_dat <= '0;
            end
            // Once the RAM is committed the operation completes, only the ack is withheld.
            if (((state == ST_ACCESS) || (state == ST_DATA)) && !wbs.wbs_cyc_i) begin
                abort <= 1'b1;
            end
            if (state == ST_DATA) begin
                rd_dat <= we_l ? 32'h0 : ram_do;
            end
        end
    end

    assign ram_en        = (state == ST_ACCESS);
    assign ram_we        = ((state == ST_ACCESS) && we_l) ? sel_l : 4'h0;
    assign wbs.wbs_ack_o = (state == ST_RESP) && wbs.wbs_cyc_i && !abort;
    assign wbs.wbs_dat_o = rd_dat;

endmodule

// File: tb/tb_wb_bram_bridge.sv
// Directed bench: DUT A (DELAY=10) and DUT B (DELAY=0), each on its own RAM model.
module tb_wb_bram_bridge;

    localparam int AW = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_bram_bridge_if bus_a ();
    wb_bram_bridge_if bus_b ();

    logic          en_a, en_b;
    logic [3:0]    we_a, we_b;
    logic [AW-1:0] a_a, a_b;
    logic [31:0]   di_a, di_b, do_a, do_b;

    wb_bram_bridge #(.RAM_AW(AW), .DELAY(10), .BASE_ADDR(32'h3800_0000)) dut_a (
        .CLK(clk), .RSTN(rst_n), .wbs(bus_a.slave),
        .ram_en(en_a), .ram_we(we_a), .ram_a(a_a), .ram_di(di_a), .ram_do(do_a));

    wb_bram_bridge #(.RAM_AW(AW), .DELAY(0), .BASE_ADDR(32'h3800_0000)) dut_b (
        .CLK(clk), .RSTN(rst_n), .wbs(bus_b.slave),
        .ram_en(en_b), .ram_we(we_b), .ram_a(a_b), .ram_di(di_b), .ram_do(do_b));

    // RAM macro behaviour: registered read, output forced to zero after an idle edge.
    logic [31:0] mem_a [2**AW];
    logic [31:0] mem_b [2**AW];
    always @(posedge clk) begin
        if (en_a) begin
            do_a <= mem_a[a_a];
            for (int i = 0; i < 4; i++) if (we_a[i]) mem_a[a_a][8*i +: 8] <= di_a[8*i +: 8];
        end else begin
            do_a <= 32'h0;
        end
        if (en_b) begin
            do_b <= mem_b[a_b];
            for (int i = 0; i < 4; i++) if (we_b[i]) mem_b[a_b][8*i +: 8] <= di_b[8*i +: 8];
        end else begin
            do_b <= 32'h0;
        end
    end

    bit dsel;
    logic          o_ack, o_en;
    logic [3:0]    o_we;
    logic [AW-1:0] o_a;
    logic [31:0]   o_di, o_dat;
    assign o_ack = dsel ? bus_b.wbs_ack_o : bus_a.wbs_ack_o;
    assign o_dat = dsel ? bus_b.wbs_dat_o : bus_a.wbs_dat_o;
    assign o_en  = dsel ? en_b : en_a;
    assign o_we  = dsel ? we_b : we_a;
    assign o_a   = dsel ? a_b  : a_a;
    assign o_di  = dsel ? di_b : di_a;

    int checks = 0;
    int failures = 0;

    int            r_ack_cnt, r_ack1, r_ack2, r_en_cnt, r_en1;
    logic [3:0]    r_we;
    logic [AW-1:0] r_a;
    logic [31:0]   r_di, r_dat;

    task automatic set_bus(input bit d, input bit cyc, input bit we,
                           input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        if (d) begin
            bus_b.wbs_cyc_i = cyc; bus_b.wbs_stb_i = cyc; bus_b.wbs_we_i = we;
            bus_b.wbs_adr_i = adr; bus_b.wbs_dat_i = dat; bus_b.wbs_sel_i = sel;
        end else begin
            bus_a.wbs_cyc_i = cyc; bus_a.wbs_stb_i = cyc; bus_a.wbs_we_i = we;
            bus_a.wbs_adr_i = adr; bus_a.wbs_dat_i = dat; bus_a.wbs_sel_i = sel;
        end
    endtask

    // Cycle 0 is the cycle whose closing edge first samples the request.
    task automatic txn(input bit d, input bit we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int drop_k, input bit hold, input int ncyc);
        bit rel;
        dsel = d;
        r_ack_cnt = 0; r_ack1 = -1; r_ack2 = -1; r_en_cnt = 0; r_en1 = -1;
        r_we = 4'hx; r_a = 'x; r_di = 'x; r_dat = 'x;
        rel = 1'b0;
        @(negedge clk);
        set_bus(d, 1'b1, we, adr, dat, sel);
        for (int k = 0; k < ncyc; k++) begin
            if (k == drop_k) set_bus(d, 1'b0, we, adr, dat, sel);
            if (o_ack) begin
                r_ack_cnt++;
                if (r_ack1 < 0) begin r_ack1 = k; r_dat = o_dat; end
                else if (r_ack2 < 0) r_ack2 = k;
                if (!hold) rel = 1'b1;
            end
            if (o_en) begin
                r_en_cnt++;
                if (r_en1 < 0) begin r_en1 = k; r_we = o_we; r_a = o_a; r_di = o_di; end
            end
            @(negedge clk);
            if (rel) set_bus(d, 1'b0, we, adr, dat, sel);
        end
        set_bus(d, 1'b0, we, adr, dat, sel);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        set_bus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_bus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        dsel = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (o_ack !== 1'b0)  begin failures++; $display("FAIL rst_ack got=%b exp=0", o_ack); end
        checks++; if (o_dat !== 32'h0) begin failures++; $display("FAIL rst_dat got=%h exp=0", o_dat); end
        checks++; if (o_en !== 1'b0)   begin failures++; $display("FAIL rst_en got=%b exp=0", o_en); end
        checks++; if (o_we !== 4'h0)   begin failures++; $display("FAIL rst_we got=%h exp=0", o_we); end
        checks++; if (o_a !== 7'h0)    begin failures++; $display("FAIL rst_a got=%h exp=0", o_a); end
        checks++; if (o_di !== 32'h0)  begin failures++; $display("FAIL rst_di got=%h exp=0", o_di); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        txn(0, 1'b1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, -1, 1'b0, 16);
        checks++; if (r_en1 !== 11)          begin failures++; $display("FAIL wr_en_cycle got=%0d exp=11", r_en1); end
        checks++; if (r_en_cnt !== 1)        begin failures++; $display("FAIL wr_en_count got=%0d exp=1", r_en_cnt); end
        checks++; if (r_a !== 7'd4)          begin failures++; $display("FAIL wr_ram_a got=%0d exp=4", r_a); end
        checks++; if (r_we !== 4'hF)         begin failures++; $display("FAIL wr_ram_we got=%h exp=f", r_we); end
        checks++; if (r_di !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_ram_di got=%h exp=deadbeef", r_di); end
        checks++; if (r_ack1 !== 13)         begin failures++; $display("FAIL wr_ack_cycle got=%0d exp=13", r_ack1); end
        checks++; if (r_ack_cnt !== 1)       begin failures++; $display("FAIL wr_ack_count got=%0d exp=1", r_ack_cnt); end
    endtask

    task automatic test_read();
        txn(0, 1'b0, 32'h3800_0010, 32'h0, 4'hF, -1, 1'b0, 16);
        checks++; if (r_dat !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_dat got=%h exp=deadbeef", r_dat); end
        checks++; if (r_ack1 !== 13)     begin failures++; $display("FAIL rd_ack_cycle got=%0d exp=13", r_ack1); end
        checks++; if (r_en1 !== 11)      begin failures++; $display("FAIL rd_en_cycle got=%0d exp=11", r_en1); end
        checks++; if (r_en_cnt !== 1)    begin failures++; $display("FAIL rd_en_count got=%0d exp=1", r_en_cnt); end
        checks++; if (r_we !== 4'h0)     begin failures++; $display("FAIL rd_ram_we got=%h exp=0", r_we); end
    endtask

    task automatic test_byte_write();
        txn(0, 1'b1, 32'h3800_0010, 32'h0000_AA00, 4'b0010, -1, 1'b0, 16);
        checks++; if (r_we !== 4'b0010)  begin failures++; $display("FAIL bw_ram_we got=%h exp=2", r_we); end
        checks++; if (r_ack1 !== 13)     begin failures++; $display("FAIL bw_ack_cycle got=%0d exp=13", r_ack1); end
        txn(0, 1'b0, 32'h3800_0010, 32'h0, 4'hF, -1, 1'b0, 16);
        checks++; if (r_dat !== 32'hDEAD_AAEF) begin failures++; $display("FAIL bw_rd_dat got=%h exp=deadaaef", r_dat); end
    endtask

    task automatic test_zero_delay();
        txn(1, 1'b1, 32'h3800_0020, 32'h1234_5678, 4'hF, -1, 1'b0, 6);
        checks++; if (r_ack1 !== 3)      begin failures++; $display("FAIL z_wr_ack_cycle got=%0d exp=3", r_ack1); end
        checks++; if (r_en1 !== 1)       begin failures++; $display("FAIL z_wr_en_cycle got=%0d exp=1", r_en1); end
        txn(1, 1'b1, 32'h3800_0020, 32'hFFFF_FFFF, 4'h0, -1, 1'b0, 6);
        checks++; if (r_ack1 !== 3)      begin failures++; $display("FAIL sel0_ack_cycle got=%0d exp=3", r_ack1); end
        checks++; if (r_en_cnt !== 1)    begin failures++; $display("FAIL sel0_en_count got=%0d exp=1", r_en_cnt); end
        checks++; if (r_we !== 4'h0)     begin failures++; $display("FAIL sel0_ram_we got=%h exp=0", r_we); end
    endtask

    task automatic test_back_to_back();
        txn(1, 1'b0, 32'h3800_0020, 32'h0, 4'hF, -1, 1'b1, 10);
        checks++; if (r_ack1 !== 3)      begin failures++; $display("FAIL b2b_ack1 got=%0d exp=3", r_ack1); end
        checks++; if (r_ack2 !== 7)      begin failures++; $display("FAIL b2b_ack2 got=%0d exp=7", r_ack2); end
        checks++; if (r_ack_cnt !== 2)   begin failures++; $display("FAIL b2b_ack_count got=%0d exp=2", r_ack_cnt); end
        checks++; if (r_dat !== 32'h1234_5678) begin failures++; $display("FAIL b2b_dat got=%h exp=12345678", r_dat); end
    endtask

    task automatic test_abort();
        txn(0, 1'b1, 32'h3800_0010, 32'h5555_5555, 4'hF, 5, 1'b0, 16);
        checks++; if (r_en_cnt !== 0)    begin failures++; $display("FAIL abort_en_count got=%0d exp=0", r_en_cnt); end
        checks++; if (r_ack_cnt !== 0)   begin failures++; $display("FAIL abort_ack_count got=%0d exp=0", r_ack_cnt); end
        txn(0, 1'b0, 32'h3800_0010, 32'h0, 4'hF, -1, 1'b0, 16);
        checks++; if (r_dat !== 32'hDEAD_AAEF) begin failures++; $display("FAIL abort_rd_dat got=%h exp=deadaaef", r_dat); end
    endtask

    task automatic test_reset_mid();
        int acks;
        int ens;
        dsel = 0;
        @(negedge clk);
        set_bus(0, 1'b1, 1'b1, 32'h3800_0040, 32'hCAFE_F00D, 4'hF);
        repeat (11) @(negedge clk);
        checks++; if (o_en !== 1'b1)     begin failures++; $display("FAIL mid_pre_en got=%b exp=1", o_en); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (o_en !== 1'b0)     begin failures++; $display("FAIL mid_en got=%b exp=0", o_en); end
        checks++; if (o_we !== 4'h0)     begin failures++; $display("FAIL mid_we got=%h exp=0", o_we); end
        checks++; if (o_ack !== 1'b0)    begin failures++; $display("FAIL mid_ack got=%b exp=0", o_ack); end
        checks++; if (o_a !== 7'h0)      begin failures++; $display("FAIL mid_a got=%h exp=0", o_a); end
        checks++; if (o_di !== 32'h0)    begin failures++; $display("FAIL mid_di got=%h exp=0", o_di); end
        checks++; if (o_dat !== 32'h0)   begin failures++; $display("FAIL mid_dat got=%h exp=0", o_dat); end
        set_bus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1 rst_n = 1'b1;
        acks = 0; ens = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (o_ack) acks++;
            if (o_en) ens++;
        end
        checks++; if (acks !== 0)        begin failures++; $display("FAIL mid_post_acks got=%0d exp=0", acks); end
        checks++; if (ens !== 0)         begin failures++; $display("FAIL mid_post_en got=%0d exp=0", ens); end
    endtask

`ifdef WB_BRAM_ADDR_CHECK_EN
    task automatic test_addr_check();
        txn(0, 1'b0, 32'h3000_0000, 32'h0, 4'hF, -1, 1'b0, 8);
        checks++; if (r_ack1 !== 1)      begin failures++; $display("FAIL ac_ack_cycle got=%0d exp=1", r_ack1); end
        checks++; if (r_ack_cnt !== 1)   begin failures++; $display("FAIL ac_ack_count got=%0d exp=1", r_ack_cnt); end
        checks++; if (r_dat !== 32'h0)   begin failures++; $display("FAIL ac_dat got=%h exp=0", r_dat); end
        checks++; if (r_en_cnt !== 0)    begin failures++; $display("FAIL ac_en_count got=%0d exp=0", r_en_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_byte_write();
        test_zero_delay();
        test_back_to_back();
        test_abort();
        test_reset_mid();
`ifdef WB_BRAM_ADDR_CHECK_EN
        test_addr_check();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
